// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and default sizes for the cpu_mem unified memory
package cpu_mem_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] word;
   } boot_entry_t;

endpackage

// File: rtl/cpu_mem_boot_rom.sv
// rtl/cpu_mem_boot_rom.sv - combinational boot image (CPU program and constants), 0 when unlisted
module boot_rom
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_data
);

   localparam int N_ENTRIES = 8;

   // Program at the bottom of memory, operands in the 0xA0 page
   localparam boot_entry_t [N_ENTRIES-1:0] IMAGE = '{
      '{addr: 8'h00, word: 16'h02A0},
      '{addr: 8'h01, word: 16'h03A1},
      '{addr: 8'h02, word: 16'h01A2},
      '{addr: 8'h03, word: 16'h0F00},
      '{addr: 8'h10, word: 16'h4010},
      '{addr: 8'hA0, word: 16'h0005},
      '{addr: 8'hA1, word: 16'h0001},
      '{addr: 8'hFF, word: 16'h8001}
   };

   always_comb begin
      o_data = '0;
      for (int k = 0; k < N_ENTRIES; k++) begin
         if (i_addr == ADDR_W'(IMAGE[k].addr)) begin
            o_data = DATA_W'(IMAGE[k].word);
         end
      end
   end

endmodule

// File: rtl/cpu_mem.sv
// rtl/cpu_mem.sv - self-loading unified program/data memory with instruction and data ports
// Optional: CPU_MEM_WR_FWD_EN makes same-cycle instruction reads see the data-port write.
module cpu_mem
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reinit,
   output logic              ready,
   output logic              init_err,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_data,
   output logic              i_valid,
   input  logic              d_en,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_ready;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_boot_word;
   logic              w_i_rd;
   logic              w_d_rd;
   logic              w_d_wr;
   logic [DATA_W-1:0] w_i_word;

   boot_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_boot_rom (
      .i_addr (r_cnt),
      .o_data (w_boot_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Single write port: the init sequencer owns it in INIT, the data port in RUN
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready     = 1'b0;
      w_we        = 1'b0;
      w_waddr     = r_cnt;
      w_wdata     = w_boot_word;
      case (r_state)
         INIT: begin
            w_we      = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == '1) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
         end
         RUN: begin
            w_ready = 1'b1;
            w_we    = d_en & d_we;
            w_waddr = d_addr;
            w_wdata = d_wdata;
            if (reinit) begin
               w_state_nxt = INIT;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign ready  = w_ready;
   assign w_i_rd = i_en & w_ready;
   assign w_d_rd = d_en & ~d_we & w_ready;
   assign w_d_wr = d_en & d_we & w_ready;

`ifdef CPU_MEM_WR_FWD_EN
   assign w_i_word = (w_d_wr && (d_addr == i_addr)) ? d_wdata : r_mem[i_addr];
`else
   assign w_i_word = r_mem[i_addr];
`endif

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_data   <= '0;
         i_valid  <= 1'b0;
         d_rdata  <= '0;
         d_rvalid <= 1'b0;
         init_err <= 1'b0;
      end else begin
         i_valid  <= w_i_rd;
         d_rvalid <= w_d_rd;
         if (w_i_rd) begin
            i_data <= w_i_word;
         end
         if (w_d_rd) begin
            d_rdata <= r_mem[d_addr];
         end
         if ((i_en | d_en) && !w_ready) begin
            init_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem.sv
// tb/tb_cpu_mem.sv - directed vector bench for cpu_mem (honours CPU_MEM_WR_FWD_EN)
module tb_cpu_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        reinit;
   logic        ready;
   logic        init_err;
   logic        i_en;
   logic [7:0]  i_addr;
   logic [15:0] i_data;
   logic        i_valid;
   logic        d_en;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_rvalid;

   int n_checks = 0;
   int n_errors = 0;

`ifdef CPU_MEM_WR_FWD_EN
   localparam logic [15:0] EXP_COLLIDE = 16'h1234;
`else
   localparam logic [15:0] EXP_COLLIDE = 16'h4010;
`endif

   typedef struct {
      logic        i_en;
      logic [7:0]  i_addr;
      logic        d_en;
      logic        d_we;
      logic [7:0]  d_addr;
      logic [15:0] d_wdata;
      logic        exp_iv;
      logic [15:0] exp_id;
      logic        exp_dv;
      logic [15:0] exp_dr;
   } vec_t;

   vec_t vecs[12];

   cpu_mem dut (
      .clk      (clk),
      .rst      (rst),
      .reinit   (reinit),
      .ready    (ready),
      .init_err (init_err),
      .i_en     (i_en),
      .i_addr   (i_addr),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .d_en     (d_en),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_rvalid (d_rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle();
      i_en = 1'b0; d_en = 1'b0; d_we = 1'b0; reinit = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string tag);
      i_en = v.i_en; i_addr = v.i_addr;
      d_en = v.d_en; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
      @(posedge clk); #1;
      chk({tag, " i_valid"}, 16'(i_valid), 16'(v.exp_iv));
      chk({tag, " i_data"}, i_data, v.exp_id);
      chk({tag, " d_rvalid"}, 16'(d_rvalid), 16'(v.exp_dv));
      chk({tag, " d_rdata"}, d_rdata, v.exp_dr);
      idle();
   endtask

   // Counts rising edges until ready is seen high, bounded
   task automatic wait_ready(output int n);
      n = 0;
      while (n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (ready) break;
      end
   endtask

   int n;

   initial begin
      vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h02A0, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
      vecs[2]  = '{1'b1, 8'h50, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
      vecs[3]  = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
      vecs[7]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'hA0, 16'h0000, 1'b1, 16'h03A1, 1'b1, 16'h0005};
      vecs[8]  = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 16'h1234, 1'b1, EXP_COLLIDE, 1'b0, 16'h0005};
      vecs[9]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0005};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1234, 1'b1, 16'h8001};
      vecs[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h8001, 1'b0, 16'h8001};

      idle();
      i_addr = '0; d_addr = '0; d_wdata = '0;
      rst = 1'b1;
      #3 rst = 1'b0;
      #10;
      chk("rst ready", 16'(ready), 16'h0);
      chk("rst init_err", 16'(init_err), 16'h0);
      chk("rst i_valid", 16'(i_valid), 16'h0);
      chk("rst d_rvalid", 16'(d_rvalid), 16'h0);
      chk("rst i_data", i_data, 16'h0);
      chk("rst d_rdata", d_rdata, 16'h0);

      // Boot load, with a data read attempted at INIT cycle 5
      @(negedge clk) rst = 1'b1;
      n = 0;
      while (n < 1000) begin
         if (n == 4) begin
            d_en = 1'b1; d_we = 1'b0; d_addr = 8'hA0;
         end
         @(posedge clk); #1;
         n++;
         if (n == 5) begin
            chk("init access d_rvalid", 16'(d_rvalid), 16'h0);
            chk("init access init_err", 16'(init_err), 16'h1);
            idle();
         end
         if (ready) break;
      end
      chk("boot load cycles", 16'(n), 16'd256);
      chk("init_err sticky in RUN", 16'(init_err), 16'h1);

      for (int k = 0; k < 12; k++) begin
         apply(vecs[k], $sformatf("vec%0d", k));
      end

      // Overwrite address 0, then reinit must restore the boot word
      apply('{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hFFFF, 1'b0, 16'h8001, 1'b0, 16'h8001}, "wr00");
      apply('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h8001}, "rd00");
      reinit = 1'b1;
      @(posedge clk); #1;
      reinit = 1'b0;
      chk("reinit ready drop", 16'(ready), 16'h0);
      wait_ready(n);
      chk("reinit load cycles", 16'(n), 16'd256);
      chk("init_err after reinit", 16'(init_err), 16'h1);
      apply('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h02A0, 1'b0, 16'h8001}, "reload00");

      // Asynchronous reset at INIT cycle 100
      reinit = 1'b1;
      @(posedge clk); #1;
      reinit = 1'b0;
      repeat (100) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midinit rst ready", 16'(ready), 16'h0);
      chk("midinit rst init_err", 16'(init_err), 16'h0);
      chk("midinit rst i_data", i_data, 16'h0);
      chk("midinit rst d_rdata", d_rdata, 16'h0);
      @(negedge clk) rst = 1'b1;
      wait_ready(n);
      chk("post-rst load cycles", 16'(n), 16'd256);
      apply('{1'b1, 8'hA0, 1'b1, 1'b0, 8'hA1, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0001}, "post-rst rd");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_mem.md
# cpu_mem

Parametrised unified program/data memory for the 16-bit accumulator CPU. Replaces the single-port, reset-preloaded array with a BRAM-inferable array that fills itself from a boot image after reset using a hardware init sequencer. It exposes a read-only instruction port and a read/write data port, both with registered, one-cycle-latency reads. It sits between the CPU control unit (fetch and MAR/MBR paths) and nothing else.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- reinit  in  1  single-cycle request to re-run the boot-image load; honoured only in RUN
- ready  out  1  high when the array is loaded and accepting accesses
- init_err  out  1  sticky; set by any access attempted while ready=0
- i_en  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_data  out  DATA_W  instruction word
- i_valid  out  1  i_data valid this cycle
- d_en  in  1  data access request
- d_we  in  1  1 = write, 0 = read (qualified by d_en)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data
- d_rvalid  out  1  d_rdata valid this cycle

## Operation
- FSM states: INIT, RUN. Reset forces INIT with init counter = 0.
- INIT: each cycle writes boot_rom(cnt) to ram[cnt], then increments cnt. After writing address 2**ADDR_W-1, go to RUN. Wrap of cnt is not used; the transition happens on the last write.
- RUN: ready=1. reinit=1 sends the FSM to INIT with cnt=0, and ready drops the next cycle.
- Data port, RUN: d_en&d_we writes ram[d_addr] and produces no rvalid. d_en&~d_we reads ram[d_addr]; the result appears next cycle with d_rvalid=1.
- Instruction port, RUN: i_en reads ram[i_addr]; the result appears next cycle with i_valid=1.
- ready=0 (INIT): i_en/d_en are ignored, with no write and no valid output, and init_err is set. init_err clears only on rst.
- reinit coinciding with a data write in RUN: the write is performed and INIT starts next cycle, overwriting it.
- When no valid output is pending, d_rdata/i_data hold their last value. The valid flags are single-cycle.
- Unlisted boot-image addresses load 0.

## Timing
- Reset values: ready=0, init_err=0, i_data=0, i_valid=0, d_rdata=0, d_rvalid=0, cnt=0, state=INIT.
- Init takes 2**ADDR_W cycles from the first rising edge after rst deasserts. ready rises on the edge after the last init write.
- Read latency is 1 cycle on both ports. A new request is accepted every cycle with no back-pressure.
- Same-address data write and instruction read in the same cycle: see Configuration.
- rst asserted mid-INIT or mid-RUN immediately forces the reset values. The load restarts from address 0, and partial array contents are don't-care.

## Configuration
- CPU_MEM_WR_FWD_EN defined: an instruction read hitting the address being written by the data port in the same cycle returns d_wdata (write-first).
- Undefined: that read returns the old array contents (read-first).
- The data port's own read/write never overlap, so the macro does not affect the data port.

## Structure
- The shared package cpu_mem_pkg holds:
  - the state enum {INIT, RUN}
  - default DATA_W/ADDR_W constants
  - the boot-image entry type (address, word).
- Sub-module boot_rom is purely combinational: ADDR_W address in, DATA_W word out. It holds the CPU program and constants and returns 0 for unlisted addresses. It is swapped per program without touching cpu_mem.

## Test plan
- Reset, then wait for ready. Expect ready to rise exactly 256 cycles after rst deasserts (defaults). Reads of i_addr 0x00 → 0x02A0, 0xA1 → 0x0001, and 0x50 → 0x0000, each with i_valid one cycle later.
- In RUN, data write 0xA5 ← 0xBEEF, then data read 0xA5 next cycle. Expect d_rdata=0xBEEF with d_rvalid one cycle after the read request, and no d_rvalid after the write.
- Same cycle: data write 0x10 ← 0x1234 and instruction read 0x10. With CPU_MEM_WR_FWD_EN, i_data=0x1234; without it, i_data equals the boot word at 0x10.
- d_en read at cycle 5 of INIT: no d_rvalid and init_err=1. init_err stays 1 through RUN and clears only on rst.
- Write 0x00 ← 0xFFFF, then pulse reinit. Expect ready=0 for 256 cycles, then the read of 0x00 returns 0x02A0.
- Assert rst at INIT cycle 100. Outputs reset immediately, and a full 256-cycle load follows release.
